// File: rtl/brjmp_pkg.sv
// Shared encodings for the branch/jump redirect unit: opcodes, rtype_fn and
// status bit positions, and the controller state type.
package brjmp_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_BMZ   = 3'b001;
  localparam logic [2:0] OP_BNZ   = 3'b010;
  localparam logic [2:0] OP_BPL   = 3'b011;
  localparam logic [2:0] OP_JRSAL = 3'b100;
  localparam logic [2:0] OP_JMP   = 3'b101;

  localparam int FN_BRZ   = 0;
  localparam int FN_JMADD = 1;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic logic is_link_op(input logic [2:0] op);
    return op == OP_JRSAL;
  endfunction

endpackage

// File: rtl/brjmp_cond.sv
// Combinational taken evaluator: decides whether a branch/jump op redirects
// given the ALU status flags captured with the request.
module brjmp_cond
  import brjmp_pkg::*;
(
  input  logic [2:0] op,
  input  logic [2:0] rtype_fn,
  input  logic [1:0] status,
  output logic       taken
);

  logic z;
  logic n;
  logic unused_fn_bit;

  assign z = status[ST_Z];
  assign n = status[ST_N];
  // bit2 of rtype_fn is reserved and has no effect on the decision
  assign unused_fn_bit = rtype_fn[2];

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_RTYPE: taken = (rtype_fn[FN_BRZ] & z) | rtype_fn[FN_JMADD];
      OP_BMZ:   taken = z;
      OP_BNZ:   taken = ~z;
      OP_BPL:   taken = ~n & ~z;
      OP_JRSAL: taken = 1'b1;
      OP_JMP:   taken = 1'b1;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/brjmp_redirect_unit.sv
// Branch/jump resolver: registers a redirect to fetch, holds flush for a fixed
// number of cycles, writes the link value on JRSAL and counts taken redirects.
module brjmp_redirect_unit
  import brjmp_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int ALIGN_BITS   = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int LINK_OFFSET  = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [2:0]        rtype_fn,
  input  logic [1:0]        status,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] pc,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic              flush,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic              fault,
  output logic [CNT_W-1:0]  taken_count
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  state_t          state;
  logic [FC_W-1:0] flush_cnt;
  logic            taken;
  logic            misaligned;
  logic            accept;

  brjmp_cond u_cond (
    .op       (op),
    .rtype_fn (rtype_fn),
    .status   (status),
    .taken    (taken)
  );

  generate
    if (ALIGN_BITS > 0) begin : g_align
      assign misaligned = |target[ALIGN_BITS-1:0];
    end else begin : g_no_align
      assign misaligned = 1'b0;
    end
  endgenerate

  // in_ready is only ever high in IDLE, so it doubles as the accept gate
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      in_ready       <= 1'b1;
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
      flush          <= 1'b0;
      link_we        <= 1'b0;
      link_data      <= '0;
      fault          <= 1'b0;
      taken_count    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      link_we        <= 1'b0;
      fault          <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && taken) begin
            if (misaligned) begin
              fault <= 1'b1;
            end else begin
              state          <= FLUSH;
              flush_cnt      <= FC_W'(FLUSH_CYCLES);
              in_ready       <= 1'b0;
              flush          <= 1'b1;
              redirect_valid <= 1'b1;
              redirect_addr  <= target;
              if (taken_count != {CNT_W{1'b1}}) begin
                taken_count <= taken_count + CNT_W'(1);
              end
              if (is_link_op(op)) begin
                link_we   <= 1'b1;
                link_data <= pc + ADDR_W'(LINK_OFFSET);
              end
            end
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt - FC_W'(1);
          // last flush cycle: reopen for requests at the next edge
          if (flush_cnt == FC_W'(1)) begin
            state    <= IDLE;
            flush    <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brjmp_redirect_unit.sv
// Directed self-checking bench for brjmp_redirect_unit; a second instance
// with a 2-bit counter exercises saturation.
module tb_brjmp_redirect_unit;
  import brjmp_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  op;
  logic [2:0]  rtype_fn;
  logic [1:0]  status;
  logic [31:0] target;
  logic [31:0] pc;

  logic        in_ready, redirect_valid, flush, link_we, fault;
  logic [31:0] redirect_addr, link_data;
  logic [15:0] taken_count;

  logic        in_ready2, redirect_valid2, flush2, link_we2, fault2;
  logic [31:0] redirect_addr2, link_data2;
  logic [1:0]  taken_count2;

  int errors = 0;
  int checks = 0;

  brjmp_redirect_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rtype_fn(rtype_fn), .status(status), .target(target), .pc(pc),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .flush(flush),
    .link_we(link_we), .link_data(link_data), .fault(fault), .taken_count(taken_count)
  );

  brjmp_redirect_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .rtype_fn(rtype_fn), .status(status), .target(target), .pc(pc),
    .redirect_valid(redirect_valid2), .redirect_addr(redirect_addr2), .flush(flush2),
    .link_we(link_we2), .link_data(link_data2), .fault(fault2), .taken_count(taken_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance through one rising edge and sample 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [2:0] fn,
                       input logic [1:0] st, input logic [31:0] tg, input logic [31:0] p);
    in_valid = v; op = o; rtype_fn = fn; status = st; target = tg; pc = p;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, OP_JMP, 3'b000, 2'b00, 32'h0, 32'h0);
    step(); step();
    checks++;
    if (in_ready !== 1'b1 || redirect_valid !== 1'b0 || flush !== 1'b0 || link_we !== 1'b0 ||
        fault !== 1'b0 || redirect_addr !== 32'h0 || link_data !== 32'h0 || taken_count !== 16'h0) begin
      errors++;
      $display("FAIL reset: rdy=%b rv=%b fl=%b lw=%b ft=%b ra=%h ld=%h cnt=%0d required rdy=1 rest 0",
               in_ready, redirect_valid, flush, link_we, fault, redirect_addr, link_data, taken_count);
    end
    rst_n = 1'b1;
    step();
    $display("reset: done");
  endtask

  task automatic test_bmz_taken();
    drive(1'b1, OP_BMZ, 3'b000, 2'b01, 32'h100, 32'h10);
    step();
    in_valid = 1'b0;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_addr !== 32'h100 || flush !== 1'b1 ||
        in_ready !== 1'b0 || taken_count !== 16'd1 || link_we !== 1'b0) begin
      errors++;
      $display("FAIL bmz_t1: rv=%b ra=%h fl=%b rdy=%b cnt=%0d lw=%b required 1 100 1 0 1 0",
               redirect_valid, redirect_addr, flush, in_ready, taken_count, link_we);
    end
    step();
    checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bmz_t2: rv=%b fl=%b rdy=%b required 0 1 0", redirect_valid, flush, in_ready);
    end
    step();
    checks++;
    if (flush !== 1'b0 || in_ready !== 1'b1 || redirect_addr !== 32'h100) begin
      errors++;
      $display("FAIL bmz_t3: fl=%b rdy=%b ra=%h required 0 1 100", flush, in_ready, redirect_addr);
    end
    $display("bmz_taken: target=0x100 count=%0d", taken_count);
  endtask

  task automatic test_not_taken();
    logic [2:0]  ops [5] = '{OP_BNZ, OP_BNZ, OP_BNZ, OP_BPL, 3'b110};
    logic [1:0]  sts [5] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ops[i], 3'b011, sts[i], 32'h800, 32'h20);
      step();
      checks++;
      if (redirect_valid !== 1'b0 || flush !== 1'b0 || in_ready !== 1'b1 ||
          fault !== 1'b0 || taken_count !== 16'd1) begin
        errors++;
        $display("FAIL not_taken[%0d]: rv=%b fl=%b rdy=%b ft=%b cnt=%0d required 0 0 1 0 1",
                 i, redirect_valid, flush, in_ready, fault, taken_count);
      end
      $display("not_taken[%0d]: op=%b status=%b", i, ops[i], sts[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_jrsal();
    drive(1'b1, OP_JRSAL, 3'b000, 2'b00, 32'h200, 32'h40);
    step();
    in_valid = 1'b0;
    checks++;
    if (link_we !== 1'b1 || link_data !== 32'h44 || redirect_valid !== 1'b1 ||
        redirect_addr !== 32'h200 || taken_count !== 16'd2) begin
      errors++;
      $display("FAIL jrsal_link: lw=%b ld=%h rv=%b ra=%h cnt=%0d required 1 44 1 200 2",
               link_we, link_data, redirect_valid, redirect_addr, taken_count);
    end
    step();
    checks++;
    if (link_we !== 1'b0 || link_data !== 32'h44) begin
      errors++;
      $display("FAIL jrsal_hold: lw=%b ld=%h required 0 44", link_we, link_data);
    end
    step();
    drive(1'b1, OP_JRSAL, 3'b000, 2'b00, 32'h202, 32'h80);
    step();
    in_valid = 1'b0;
    checks++;
    if (fault !== 1'b1 || link_we !== 1'b0 || flush !== 1'b0 || redirect_valid !== 1'b0 ||
        in_ready !== 1'b1 || taken_count !== 16'd2 || link_data !== 32'h44) begin
      errors++;
      $display("FAIL jrsal_misalign: ft=%b lw=%b fl=%b rv=%b rdy=%b cnt=%0d ld=%h required 1 0 0 0 1 2 44",
               fault, link_we, flush, redirect_valid, in_ready, taken_count, link_data);
    end
    step();
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_pulse: ft=%b required 0", fault);
    end
    $display("jrsal: link=0x%h misaligned fault seen", link_data);
  endtask

  task automatic test_rtype_back_to_back();
    drive(1'b1, OP_RTYPE, 3'b001, 2'b00, 32'h300, 32'h50);
    step();
    checks++;
    if (redirect_valid !== 1'b0 || in_ready !== 1'b1 || taken_count !== 16'd2) begin
      errors++;
      $display("FAIL rtype_brz_nz: rv=%b rdy=%b cnt=%0d required 0 1 2", redirect_valid, in_ready, taken_count);
    end
    drive(1'b1, OP_RTYPE, 3'b010, 2'b00, 32'h300, 32'h50);
    step();
    // held request issued while flushing; must wait until in_ready returns
    drive(1'b1, OP_RTYPE, 3'b001, 2'b01, 32'h500, 32'h60);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_addr !== 32'h300 || taken_count !== 16'd3) begin
      errors++;
      $display("FAIL rtype_jmadd: rv=%b ra=%h cnt=%0d required 1 300 3", redirect_valid, redirect_addr, taken_count);
    end
    step();
    checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b1 || in_ready !== 1'b0 || redirect_addr !== 32'h300) begin
      errors++;
      $display("FAIL held_t2: rv=%b fl=%b rdy=%b ra=%h required 0 1 0 300",
               redirect_valid, flush, in_ready, redirect_addr);
    end
    step();
    checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL held_t3: rv=%b fl=%b rdy=%b required 0 0 1", redirect_valid, flush, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_addr !== 32'h500 || taken_count !== 16'd4) begin
      errors++;
      $display("FAIL held_accept: rv=%b ra=%h cnt=%0d required 1 500 4", redirect_valid, redirect_addr, taken_count);
    end
    step(); step();
    $display("rtype_back_to_back: count=%0d", taken_count);
  endtask

  task automatic test_reset_mid_flush();
    drive(1'b1, OP_JMP, 3'b000, 2'b00, 32'h600, 32'h70);
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (flush !== 1'b0 || in_ready !== 1'b1 || taken_count !== 16'd0 || redirect_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_flush: fl=%b rdy=%b cnt=%0d ra=%h required 0 1 0 0",
               flush, in_ready, taken_count, redirect_addr);
    end
    drive(1'b1, OP_BPL, 3'b000, 2'b00, 32'h700, 32'h74);
    step();
    in_valid = 1'b0;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_addr !== 32'h700 || taken_count !== 16'd1 || flush !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: rv=%b ra=%h cnt=%0d fl=%b required 1 700 1 1",
               redirect_valid, redirect_addr, taken_count, flush);
    end
    step(); step();
    $display("reset_mid_flush: count=%0d", taken_count);
  endtask

  task automatic test_saturate();
    logic [1:0] exp [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OP_JMP, 3'b000, 2'b00, 32'h900, 32'h0);
      step();
      in_valid = 1'b0;
      checks++;
      if (taken_count2 !== exp[i] || redirect_valid2 !== 1'b1) begin
        errors++;
        $display("FAIL saturate[%0d]: cnt=%0d rv=%b required %0d 1", i, taken_count2, redirect_valid2, exp[i]);
      end
      $display("saturate[%0d]: count=%0d", i, taken_count2);
      step(); step();
    end
  endtask

  initial begin
    test_reset();
    test_bmz_taken();
    test_not_taken();
    test_jrsal();
    test_rtype_back_to_back();
    test_reset_mid_flush();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
